// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory controller: FSM state
// encodings, default UART register addresses and status-word bit positions.
package data_mem_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_UR       = 3'd4,
        ST_UW_SETUP = 3'd5,
        ST_UW_PULSE = 3'd6,
        ST_DONE     = 3'd7
    } mem_state_e;

    localparam logic [15:0] UART_DATA_ADDR_DEF = 16'hBF00;
    localparam logic [15:0] UART_STAT_ADDR_DEF = 16'hBF01;

    localparam int STAT_TX_READY_BIT = 0;
    localparam int STAT_RX_READY_BIT = 1;

endpackage

// File: rtl/data_mem_ctrl_uart_status.sv
// Combinational formatter for the UART status word returned on a read of
// the status register: TX ready needs both the holding and shift registers empty.
module data_mem_ctrl_uart_status
    import data_mem_ctrl_pkg::*;
(
    input  logic        data_ready,
    input  logic        tbre,
    input  logic        tsre,
    output logic [15:0] status_word
);

    always_comb begin
        status_word                    = 16'h0000;
        status_word[STAT_TX_READY_BIT] = tbre & tsre;
        status_word[STAT_RX_READY_BIT] = data_ready;
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data-memory controller: sequences SRAM and UART bus cycles for
// loads/stores and stalls the pipeline until each access completes.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter logic [15:0] UART_DATA_ADDR = UART_DATA_ADDR_DEF,
    parameter logic [15:0] UART_STAT_ADDR = UART_STAT_ADDR_DEF,
    parameter int          RAM_ADDR_W     = 18
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [15:0]           address,
    input  logic [15:0]           write_data,
    output logic [15:0]           read_data,
    output logic                  stall,
    output logic [RAM_ADDR_W-1:0] ram1_addr,
    output logic [15:0]           ram1_data_o,
    input  logic [15:0]           ram1_data_i,
    output logic                  ram1_data_oe,
    output logic                  ram1_en_n,
    output logic                  ram1_oe_n,
    output logic                  ram1_we_n,
    output logic                  uart_rdn,
    output logic                  uart_wrn,
    input  logic                  uart_data_ready,
    input  logic                  uart_tbre,
    input  logic                  uart_tsre
);

    mem_state_e  state_reg;
    logic        request;
    logic        status_access;
    logic        uart_data_access;
    logic [15:0] status_word;

    assign request          = mem_read | mem_write;
    assign status_access    = (address == UART_STAT_ADDR);
    assign uart_data_access = (address == UART_DATA_ADDR);

    // Status accesses finish in the request cycle; reset drops stall at once.
    assign stall = request & (state_reg != ST_DONE) & ~status_access & rst;

    data_mem_ctrl_uart_status u_status (
        .data_ready  (uart_data_ready),
        .tbre        (uart_tbre),
        .tsre        (uart_tsre),
        .status_word (status_word)
    );

    // Strobes are registered and set on the edge entering the state they belong to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            read_data    <= 16'h0000;
            ram1_addr    <= '0;
            ram1_data_o  <= 16'h0000;
            ram1_data_oe <= 1'b0;
            ram1_en_n    <= 1'b1;
            ram1_oe_n    <= 1'b1;
            ram1_we_n    <= 1'b1;
            uart_rdn     <= 1'b1;
            uart_wrn     <= 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (request && !status_access) begin
                        ram1_addr <= {{(RAM_ADDR_W-16){1'b0}}, address};
                        if (mem_write) begin
                            ram1_data_oe <= 1'b1;
                            if (uart_data_access) begin
                                ram1_data_o <= {8'h00, write_data[7:0]};
                                state_reg   <= ST_UW_SETUP;
                            end else begin
                                ram1_data_o <= write_data;
                                ram1_en_n   <= 1'b0;
                                state_reg   <= ST_WR_SETUP;
                            end
                        end else if (uart_data_access) begin
                            uart_rdn  <= 1'b0;
                            state_reg <= ST_UR;
                        end else begin
                            ram1_en_n <= 1'b0;
                            ram1_oe_n <= 1'b0;
                            state_reg <= ST_RD;
                        end
                    end else if (mem_read && !mem_write && status_access) begin
                        read_data <= status_word;
                    end
                end
                ST_RD: begin
                    read_data <= ram1_data_i;
                    ram1_en_n <= 1'b1;
                    ram1_oe_n <= 1'b1;
                    state_reg <= ST_DONE;
                end
                ST_WR_SETUP: begin
                    ram1_we_n <= 1'b0;
                    state_reg <= ST_WR_PULSE;
                end
                ST_WR_PULSE: begin
                    // Chip enable and data stay driven through DONE as hold time.
                    ram1_we_n <= 1'b1;
                    state_reg <= ST_DONE;
                end
                ST_UR: begin
                    read_data <= {8'h00, ram1_data_i[7:0]};
                    uart_rdn  <= 1'b1;
                    state_reg <= ST_DONE;
                end
                ST_UW_SETUP: begin
                    uart_wrn  <= 1'b0;
                    state_reg <= ST_UW_PULSE;
                end
                ST_UW_PULSE: begin
                    uart_wrn  <= 1'b1;
                    state_reg <= ST_DONE;
                end
                ST_DONE: begin
                    ram1_en_n    <= 1'b1;
                    ram1_oe_n    <= 1'b1;
                    ram1_we_n    <= 1'b1;
                    ram1_data_oe <= 1'b0;
                    uart_rdn     <= 1'b1;
                    uart_wrn     <= 1'b1;
                    state_reg    <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: SRAM/UART device models on the bus,
// a transaction-level reference model, directed cases then random traffic.
module tb_data_mem_ctrl;

    localparam logic [15:0] UDATA = 16'hBF00;
    localparam logic [15:0] USTAT = 16'hBF01;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [15:0] address, write_data;
    logic [15:0] read_data;
    logic        stall;
    logic [17:0] ram1_addr;
    logic [15:0] ram1_data_o, ram1_data_i;
    logic        ram1_data_oe, ram1_en_n, ram1_oe_n, ram1_we_n;
    logic        uart_rdn, uart_wrn;
    logic        uart_data_ready, uart_tbre, uart_tsre;
    logic [15:0] uart_rx;

    int checks   = 0;
    int failures = 0;

    data_mem_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .address         (address),
        .write_data      (write_data),
        .read_data       (read_data),
        .stall           (stall),
        .ram1_addr       (ram1_addr),
        .ram1_data_o     (ram1_data_o),
        .ram1_data_i     (ram1_data_i),
        .ram1_data_oe    (ram1_data_oe),
        .ram1_en_n       (ram1_en_n),
        .ram1_oe_n       (ram1_oe_n),
        .ram1_we_n       (ram1_we_n),
        .uart_rdn        (uart_rdn),
        .uart_wrn        (uart_wrn),
        .uart_data_ready (uart_data_ready),
        .uart_tbre       (uart_tbre),
        .uart_tsre       (uart_tsre)
    );

    always #5 clk = ~clk;

    // Bus-side device models: SRAM array and a UART receive byte.
    logic [15:0] sram [0:65535] = '{default: 16'h0000};

    always @(posedge clk) begin
        if (!ram1_en_n && !ram1_we_n && ram1_data_oe)
            sram[ram1_addr[15:0]] <= ram1_data_o;
    end

    assign ram1_data_i = (!ram1_en_n && !ram1_oe_n) ? sram[ram1_addr[15:0]] :
                         (!uart_rdn) ? uart_rx : 16'h0000;

    // Strobe monitor, cumulative counts sampled mid-cycle.
    int          we_cnt = 0, wrn_cnt = 0, rdn_cnt = 0, en_cnt = 0, contention_cnt = 0;
    logic [17:0] we_addr = '0;
    logic [15:0] wrn_data = '0;

    always @(negedge clk) begin
        if (!ram1_we_n) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= ram1_addr;
        end
        if (!uart_wrn) begin
            wrn_cnt  <= wrn_cnt + 1;
            wrn_data <= ram1_data_o;
        end
        if (!uart_rdn)  rdn_cnt <= rdn_cnt + 1;
        if (!ram1_en_n) en_cnt  <= en_cnt + 1;
        if (ram1_data_oe && !ram1_oe_n) contention_cnt <= contention_cnt + 1;
    end

    // Reference model state
    logic [15:0] ref_mem [int];
    logic [15:0] exp_rd;
    int          txn_no = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_txn(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [15:0] wd);
        int exp_lat, exp_we, exp_wrn, exp_rdn, lat;
        int we0, wrn0, rdn0, en0;
        exp_we = 0; exp_wrn = 0; exp_rdn = 0; exp_lat = 0;
        if (wr) begin
            if (addr == UDATA) begin
                exp_lat = 3; exp_wrn = 1;
            end else if (addr != USTAT) begin
                exp_lat = 3; exp_we = 1;
                ref_mem[int'(addr)] = wd;
            end
        end else if (rd) begin
            if (addr == USTAT) begin
                exp_rd = (uart_data_ready ? 16'd2 : 16'd0) + ((uart_tbre && uart_tsre) ? 16'd1 : 16'd0);
            end else if (addr == UDATA) begin
                exp_lat = 2; exp_rdn = 1;
                exp_rd  = uart_rx % 16'd256;
            end else begin
                exp_lat = 2;
                exp_rd  = ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : 16'h0000;
            end
        end

        @(posedge clk); #1;
        we0 = we_cnt; wrn0 = wrn_cnt; rdn0 = rdn_cnt; en0 = en_cnt;
        mem_read = rd; mem_write = wr; address = addr; write_data = wd;
        lat = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (!stall) break;
            lat++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk); #1;

        chk("latency", lat, exp_lat);
        chk("read_data", read_data, exp_rd);
        chk("we_pulses", we_cnt - we0, exp_we);
        chk("wrn_pulses", wrn_cnt - wrn0, exp_wrn);
        chk("rdn_pulses", rdn_cnt - rdn0, exp_rdn);
        if (exp_we != 0)
            chk("we_addr", we_addr, {2'b00, addr});
        if (exp_wrn != 0) begin
            chk("uart_wr_data", wrn_data, {8'h00, wd[7:0]});
            chk("uart_wr_en_n", en_cnt - en0, 0);
        end
        if (exp_rdn != 0)
            chk("uart_rd_en_n", en_cnt - en0, 0);
        txn_no++;
        $display("txn %0d rd=%0b wr=%0b addr=%04h wdata=%04h stall_cycles=%0d read_data=%04h",
                 txn_no, rd, wr, addr, wd, lat, read_data);
    endtask

    initial begin
        logic [15:0] a, d;
        int          k, rw;

        rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        address = 16'h0000; write_data = 16'h0000;
        uart_data_ready = 1'b0; uart_tbre = 1'b0; uart_tsre = 1'b0; uart_rx = 16'h0000;
        exp_rd = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_read_data", read_data, 16'h0000);
        chk("rst_stall", stall, 1'b0);
        chk("rst_strobes", {ram1_en_n, ram1_oe_n, ram1_we_n, uart_rdn, uart_wrn}, 5'b11111);
        chk("rst_data_oe", ram1_data_oe, 1'b0);
        chk("rst_data_o", ram1_data_o, 16'h0000);
        chk("rst_addr", ram1_addr, 18'h0);
        rst = 1'b1;

        // Directed cases
        do_txn(1'b0, 1'b1, 16'h0040, 16'h1234);
        do_txn(1'b1, 1'b0, 16'h0040, 16'h0000);
        uart_data_ready = 1'b1; uart_tbre = 1'b1; uart_tsre = 1'b0;
        do_txn(1'b1, 1'b0, USTAT, 16'h0000);
        do_txn(1'b0, 1'b1, UDATA, 16'hAB55);
        uart_rx = 16'hFF7E;
        do_txn(1'b1, 1'b0, UDATA, 16'h0000);
        do_txn(1'b1, 1'b1, 16'h0010, 16'hBEEF);
        do_txn(1'b1, 1'b0, 16'h0010, 16'h0000);
        do_txn(1'b0, 1'b1, USTAT, 16'h5A5A);

        // Reset in the middle of an SRAM write pulse
        @(posedge clk); #1;
        mem_write = 1'b1; address = 16'h0100; write_data = 16'hCAFE;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (!ram1_we_n) break;
        end
        chk("midrst_we_low", ram1_we_n, 1'b0);
        #1 rst = 1'b0;
        #1;
        chk("midrst_we_n", ram1_we_n, 1'b1);
        chk("midrst_stall", stall, 1'b0);
        chk("midrst_en_n", ram1_en_n, 1'b1);
        chk("midrst_data_oe", ram1_data_oe, 1'b0);
        mem_write = 1'b0;
        exp_rd = 16'h0000;
        @(posedge clk); #1;
        rst = 1'b1;
        do_txn(1'b1, 1'b0, 16'h0040, 16'h0000);

        // Random traffic against the reference model
        for (int n = 0; n < 60; n++) begin
            k  = $urandom_range(0, 9);
            rw = $urandom_range(0, 2);
            if (k < 6)      a = 16'($urandom_range(0, 63));
            else if (k < 8) a = UDATA;
            else            a = USTAT;
            d = 16'($urandom);
            uart_rx         = 16'($urandom);
            uart_data_ready = 1'($urandom);
            uart_tbre       = 1'($urandom);
            uart_tsre       = 1'($urandom);
            do_txn(rw != 1, rw != 0, a, d);
        end

        chk("no_bus_contention", contention_cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
